div_edge_monitor: RTL and testbench

Edge monitor and event counter for the divided-clock output of the clock divider. It samples the divided clock (a registered signal in the `clk` domain, so no synchronizer is needed) and emits single-cycle rise and fall strobes. It counts rising edges modulo `MOD` with a wrap strobe, and raises a sticky stall flag when the divided clock stops toggling. Downstream logic uses the strobes as clock enables instead of clocking flops from the divided signal.

---
 rtl/div_edge_monitor.sv | 102 ++++++++++
 tb/tb_div_edge_monitor.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/div_edge_monitor.sv
// Edge monitor for the divided clock: one-cycle rise/fall strobes, a modulo rising-edge
// counter with wrap strobe, and a sticky stall watchdog. All outputs are registered.
module div_edge_monitor #(
  parameter int CNT_W   = 8,
  parameter int MOD     = 10,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_in,
  input  logic             enable,
  input  logic             clear,
  input  logic             stall_clr,
  output logic             rise_stb,
  output logic             fall_stb,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             wrap_stb,
  output logic             stall
);

  localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  LP_CNT_MAX  = CNT_W'(MOD - 1);
  localparam logic [IDLE_W-1:0] LP_IDLE_MAX = IDLE_W'(TIMEOUT - 1);

  logic             r_div_q;
  logic             r_primed;
  logic             r_rise_stb;
  logic             r_fall_stb;
  logic [CNT_W-1:0] r_edge_cnt;
  logic             r_wrap_stb;
  logic             r_stall;
  logic [IDLE_W-1:0] r_idle;

  logic w_rise;
  logic w_fall;
  logic w_any_edge;

  // Until the first sample is taken r_div_q is meaningless, so no edge may be reported.
  assign w_rise     = r_primed & div_in & ~r_div_q;
  assign w_fall     = r_primed & ~div_in & r_div_q;
  assign w_any_edge = w_rise | w_fall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div_q    <= 1'b0;
      r_primed   <= 1'b0;
      r_rise_stb <= 1'b0;
      r_fall_stb <= 1'b0;
    end else begin
      r_div_q    <= div_in;
      r_primed   <= 1'b1;
      r_rise_stb <= w_rise;
      r_fall_stb <= w_fall;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_edge_cnt <= '0;
      r_wrap_stb <= 1'b0;
    end else if (clear) begin
      r_edge_cnt <= '0;
      r_wrap_stb <= 1'b0;
    end else if (enable && w_rise) begin
      if (r_edge_cnt == LP_CNT_MAX) begin
        r_edge_cnt <= '0;
        r_wrap_stb <= 1'b1;
      end else begin
        r_edge_cnt <= r_edge_cnt + CNT_W'(1);
        r_wrap_stb <= 1'b0;
      end
    end else begin
      r_wrap_stb <= 1'b0;
    end
  end

  // Idle counter saturates at TIMEOUT-1; stall is sticky until stall_clr or reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idle  <= '0;
      r_stall <= 1'b0;
    end else if (stall_clr) begin
      r_idle  <= '0;
      r_stall <= 1'b0;
    end else if (!enable || !r_primed) begin
      r_idle  <= '0;
    end else if (w_any_edge) begin
      r_idle  <= '0;
    end else if (r_idle == LP_IDLE_MAX) begin
      r_stall <= 1'b1;
    end else begin
      r_idle  <= r_idle + IDLE_W'(1);
    end
  end

  assign rise_stb = r_rise_stb;
  assign fall_stb = r_fall_stb;
  assign edge_cnt = r_edge_cnt;
  assign wrap_stb = r_wrap_stb;
  assign stall    = r_stall;

endmodule

// File: tb/tb_div_edge_monitor.sv
// Directed bench for div_edge_monitor: priming, counting/wrap, enable gating, clear,
// stall watchdog, clear-vs-timeout, and asynchronous reset mid-operation.
module tb_div_edge_monitor;

  logic       clk;
  logic       reset;
  logic       div_in;
  logic       enable;
  logic       clear;
  logic       stall_clr;
  logic       rise_stb;
  logic       fall_stb;
  logic [7:0] edge_cnt;
  logic       wrap_stb;
  logic       stall;

  int checks;
  int failures;

  div_edge_monitor #(.CNT_W(8), .MOD(10), .TIMEOUT(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .div_in    (div_in),
    .enable    (enable),
    .clear     (clear),
    .stall_clr (stall_clr),
    .rise_stb  (rise_stb),
    .fall_stb  (fall_stb),
    .edge_cnt  (edge_cnt),
    .wrap_stb  (wrap_stb),
    .stall     (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rise(input int exp_cnt, input logic exp_wrap);
    div_in = 1'b1;
    cyc();
    chk("rise_stb_on", 32'(rise_stb), 32'd1);
    chk("fall_stb_off_at_rise", 32'(fall_stb), 32'd0);
    chk("edge_cnt", 32'(edge_cnt), 32'(exp_cnt));
    chk("wrap_stb_at_rise", 32'(wrap_stb), 32'(exp_wrap));
    cyc();
    chk("rise_stb_one_cycle", 32'(rise_stb), 32'd0);
    chk("wrap_stb_one_cycle", 32'(wrap_stb), 32'd0);
    cyc();
  endtask

  task automatic drive_fall();
    div_in = 1'b0;
    cyc();
    chk("fall_stb_on", 32'(fall_stb), 32'd1);
    chk("rise_stb_off_at_fall", 32'(rise_stb), 32'd0);
    cyc();
    chk("fall_stb_one_cycle", 32'(fall_stb), 32'd0);
    cyc();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b0;
    div_in    = 1'b1;
    enable    = 1'b1;
    clear     = 1'b0;
    stall_clr = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_rise_stb", 32'(rise_stb), 32'd0);
    chk("reset_fall_stb", 32'(fall_stb), 32'd0);
    chk("reset_edge_cnt", 32'(edge_cnt), 32'd0);
    chk("reset_wrap_stb", 32'(wrap_stb), 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);

    // Release with div_in already high: priming must not report a rise.
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("prime_no_rise", 32'(rise_stb), 32'd0);
      chk("prime_cnt_zero", 32'(edge_cnt), 32'd0);
    end

    // Normal counting: toggle every 3 clk, 10 rises wrap to 0.
    drive_fall();
    for (int k = 1; k <= 10; k++) begin
      drive_rise(k % 10, (k == 10));
      drive_fall();
    end

    // Enable gating: count to 3, then 4 gated rises leave it at 3.
    for (int k = 1; k <= 3; k++) begin
      drive_rise(k, 1'b0);
      drive_fall();
    end
    enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_rise(3, 1'b0);
      drive_fall();
    end
    enable = 1'b1;
    drive_rise(4, 1'b0);
    drive_fall();

    // Clear coincident with a rise wins.
    clear = 1'b1;
    drive_rise(0, 1'b0);
    clear = 1'b0;

    // Stall: after the fall, 16 idle enabled edges set stall.
    div_in = 1'b0;
    cyc();
    chk("stall_fall_stb", 32'(fall_stb), 32'd1);
    for (int n = 1; n <= 16; n++) begin
      cyc();
      chk("stall_timing", 32'(stall), 32'(n == 16));
    end
    drive_rise(1, 1'b0);
    chk("stall_sticky_rise", 32'(stall), 32'd1);
    drive_fall();
    chk("stall_sticky_fall", 32'(stall), 32'd1);
    stall_clr = 1'b1;
    cyc();
    chk("stall_cleared", 32'(stall), 32'd0);
    stall_clr = 1'b0;

    // stall_clr on the 16th idle edge beats the timeout; idle restarts.
    for (int n = 1; n <= 15; n++) begin
      cyc();
      chk("clr_vs_to_pre", 32'(stall), 32'd0);
    end
    stall_clr = 1'b1;
    cyc();
    chk("clr_vs_to_wins", 32'(stall), 32'd0);
    stall_clr = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      cyc();
      chk("clr_vs_to_restart", 32'(stall), 32'(n == 16));
    end

    // Bring count to 7 with stall still set, then reset between edges.
    for (int k = 2; k <= 7; k++) begin
      drive_rise(k, 1'b0);
      drive_fall();
    end
    chk("pre_reset_cnt", 32'(edge_cnt), 32'd7);
    chk("pre_reset_stall", 32'(stall), 32'd1);
    div_in = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk("async_rise_stb", 32'(rise_stb), 32'd0);
    chk("async_fall_stb", 32'(fall_stb), 32'd0);
    chk("async_edge_cnt", 32'(edge_cnt), 32'd0);
    chk("async_wrap_stb", 32'(wrap_stb), 32'd0);
    chk("async_stall", 32'(stall), 32'd0);
    #2;
    reset = 1'b1;
    cyc();
    chk("reprime_no_rise", 32'(rise_stb), 32'd0);
    chk("reprime_cnt", 32'(edge_cnt), 32'd0);
    drive_fall();
    drive_rise(1, 1'b0);
    chk("post_reset_stall", 32'(stall), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
